// File: rtl/car_sensor_conditioner.sv
// car_sensor_conditioner
//   Conditions the side-road loop detector for the traffic-light controller.
//   The raw asynchronous sensor passes through a two-flop synchroniser and a
//   debouncer. Each debounced rising edge adds one car to a saturating queue.
//   While the side road is green, one queued car is released every
//   SERVE_CYCLES cycles. car_req stays high while any car is waiting.
//
//   Optional build macro: CAR_STUCK_DETECT_EN
//     Defined   - a sensor that stays present for STUCK_CYCLES cycles raises a
//                 sticky sensor_fault and masks further arrivals. The fault
//                 clears on reset or once the debounced sensor has been low
//                 for DEBOUNCE cycles.
//     Undefined - no stuck logic is built and sensor_fault is tied to 0.
//
// Ports
//   clock         in   system clock, rising edge
//   reset         in   synchronous, active-high
//   sensor_raw    in   raw loop detector (asynchronous, may bounce)
//   normal_green  in   1 while the side road shows green
//   car_req       out  car_count != 0 (drives the controller 'in' input)
//   car_count     out  cars currently waiting
//   queue_full    out  car_count == MAX_CARS
//   sensor_fault  out  stuck-sensor flag (0 unless CAR_STUCK_DETECT_EN)
module car_sensor_conditioner #(
  parameter int DEBOUNCE     = 4,
  parameter int SERVE_CYCLES = 8,
  parameter int MAX_CARS     = 7,
  parameter int STUCK_CYCLES = 64,
  parameter int COUNT_W      = $clog2(MAX_CARS + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               sensor_raw,
  input  logic               normal_green,
  output logic               car_req,
  output logic [COUNT_W-1:0] car_count,
  output logic               queue_full,
  output logic               sensor_fault
);

  localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int TM_W = (SERVE_CYCLES > 1) ? $clog2(SERVE_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAITING = 2'd1,
    SERVING = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic               sync_p0;     // first synchroniser flop, read only by sync_p1
  logic               sync_p1;     // synchronised sensor level
  logic [DB_W-1:0]    db_cnt;
  logic               db_p2;       // debounced level
  logic               db_d_p3;     // debounced level delayed one cycle
  logic [TM_W-1:0]    serve_tm;
  logic [COUNT_W-1:0] count_nxt;
  logic               arr;
  logic               dep;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c);
    sat_inc = (c == COUNT_W'(MAX_CARS)) ? c : c + COUNT_W'(1);
  endfunction

  function automatic logic [COUNT_W-1:0] sat_dec(input logic [COUNT_W-1:0] c);
    sat_dec = (c == '0) ? c : c - COUNT_W'(1);
  endfunction

  // Stage 0/1: two-flop synchroniser
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= sensor_raw;
      sync_p1 <= sync_p0;
    end
  end

  // Stage 2: debouncer; a new level must persist DEBOUNCE cycles
  always_ff @(posedge clock) begin
    if (reset) begin
      db_cnt <= '0;
      db_p2  <= 1'b0;
    end else if (sync_p1 != db_p2) begin
      if (db_cnt == DB_W'(DEBOUNCE - 1)) begin
        db_p2  <= sync_p1;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end else begin
      db_cnt <= '0;
    end
  end

  // Stage 3: edge detect on the debounced level
  always_ff @(posedge clock) begin
    if (reset) db_d_p3 <= 1'b0;
    else       db_d_p3 <= db_p2;
  end

`ifdef CAR_STUCK_DETECT_EN
  localparam int ST_W = (STUCK_CYCLES > 1) ? $clog2(STUCK_CYCLES) : 1;

  logic [ST_W-1:0] stuck_cnt;
  logic [DB_W-1:0] clr_cnt;
  logic            fault;

  // The stuck counter saturates once the fault is raised so a parked car
  // keeps the flag asserted without wrapping.
  always_ff @(posedge clock) begin
    if (reset) begin
      stuck_cnt <= '0;
      clr_cnt   <= '0;
      fault     <= 1'b0;
    end else if (db_p2) begin
      clr_cnt <= '0;
      if (stuck_cnt == ST_W'(STUCK_CYCLES - 1)) fault <= 1'b1;
      else                                      stuck_cnt <= stuck_cnt + ST_W'(1);
    end else begin
      stuck_cnt <= '0;
      if (fault) begin
        if (clr_cnt == DB_W'(DEBOUNCE - 1)) begin
          fault   <= 1'b0;
          clr_cnt <= '0;
        end else begin
          clr_cnt <= clr_cnt + DB_W'(1);
        end
      end else begin
        clr_cnt <= '0;
      end
    end
  end

  assign sensor_fault = fault;
  assign arr          = db_p2 & ~db_d_p3 & ~fault;
`else
  assign sensor_fault = 1'b0;
  assign arr          = db_p2 & ~db_d_p3;
`endif

  // Departure fires on the last cycle of each green serve interval.
  assign dep = normal_green && (car_count != '0) &&
               (serve_tm == TM_W'(SERVE_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset || !normal_green || (car_count == '0)) serve_tm <= '0;
    else if (serve_tm == TM_W'(SERVE_CYCLES - 1))    serve_tm <= '0;
    else                                             serve_tm <= serve_tm + TM_W'(1);
  end

  // A simultaneous arrival and departure cancel, even when the queue is full.
  always_comb begin
    count_nxt = car_count;
    if (arr && !dep)      count_nxt = sat_inc(car_count);
    else if (dep && !arr) count_nxt = sat_dec(car_count);
  end

  always_ff @(posedge clock) begin
    if (reset) car_count <= '0;
    else       car_count <= count_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arr) state_nxt = WAITING;
      WAITING: if (normal_green) state_nxt = SERVING;
      SERVING: begin
        if (count_nxt == '0)    state_nxt = IDLE;
        else if (!normal_green) state_nxt = WAITING;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign car_req    = (car_count != '0);
  assign queue_full = (car_count == COUNT_W'(MAX_CARS));

endmodule
